soc_bus_ctrl: RTL and testbench
===============================

# soc_bus_ctrl

Shared system bus controller between the two bus masters in the alioth SoC: the CPU load/store port (master 0) and the JTAG debug memory port (master 1). It arbitrates round-robin between them, decodes the granted address onto one of NUM_SLV slaves (RAM, timer, UART, GPIO, SPI), and sequences a single outstanding transaction. Each transaction ends in one response cycle: slave data, or an error for an unmapped address or a slave timeout. It sits in `alioth_soc_top` between `cpu_top`/`jtag_top` and the peripherals.

## Interface
- NUM_SLV, 5, number of slaves; slave i is selected by addr[31:28] == i.
- TIMEOUT, 255, cycles to wait for a slave ack before an error response (≥1).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1  master request; held with its command until that master's ack.
- m0_we, m1_we  in  1  write enable.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_rdata, m1_rdata  out  32  read data, valid while the matching ack is high.
- m0_err, m1_err  out  1  error flag, valid while the matching ack is high.
- s_req  out  1  slave strobe.
- s_sel  out  NUM_SLV  one-hot slave select.
- s_we, s_addr, s_wdata  out  1/32/32  registered command.
- s_rdata  in  32*NUM_SLV  slave read data, flattened; slave i is at [32i+31:32i].
- s_ack  in  NUM_SLV  per-slave completion, single-cycle.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if any request is present, the arbiter picks a winner and the command is latched. A mapped address goes to BUSY. An unmapped address (addr[31:28] ≥ NUM_SLV) goes to RESP with err=1 and rdata=0.
- Arbitration: round-robin on a 1-bit last-grant pointer, reset to 1 so master 0 wins the first tie. A lone requester always wins. On a tie, the master not granted last wins. The pointer updates on each grant.
- BUSY: s_req, s_sel, s_we, s_addr and s_wdata are driven from registers.
  - On s_ack[sel]: capture s_rdata slice, err=0, go to RESP.
  - Acks from unselected slaves are ignored.
  - A timeout counter clears on entry and increments each BUSY cycle. If it reaches TIMEOUT with no ack: err=1, rdata=0, go to RESP.
  - If an ack and the timeout occur in the same cycle, the ack wins.
- RESP: pulse ack, rdata and err to the granted master only, then go to IDLE. The other master's outputs stay 0.
- Masters deassert or change their request on the edge after their ack. Requests are not sampled in RESP.
- Writes complete the same way. The rdata returned for a write is the slave's value and is don't-care.

## Timing
- Reset values: state IDLE, all outputs 0 (s_req, s_sel, s_we, s_addr, s_wdata, m*_ack, m*_rdata, m*_err).
- Reset applied mid-transaction clears state immediately: s_req drops asynchronously and no ack is issued.
- Req seen in IDLE at cycle 0 → s_req high in cycles 1..k, where k is the slave ack cycle → m_ack in cycle k+1 → IDLE in cycle k+2.
- Minimum latency: ack in cycle 2, 3-cycle occupancy.
- Unmapped address: m_ack in cycle 1.
- Timeout: m_ack in cycle TIMEOUT+1.
- s_req is deasserted in the RESP cycle. Back-to-back grants are separated by at least one IDLE cycle.
- Counter width is $clog2(TIMEOUT+1). It never wraps; it saturates at exit.

## Structure
- `defines.v` holds:
  - BUS_ADDR_WIDTH and BUS_DATA_WIDTH.
  - Slave index constants: SLV_RAM=0, SLV_TIMER=1, SLV_UART=2, SLV_GPIO=3, SLV_SPI=4.
  - State encodings for IDLE, BUSY and RESP.
- One sub-module, `rr_arb2`: 2-requester round-robin arbiter with the grant-pointer register and a `grant_en` update strobe.
- Decode, the FSM, the timeout counter and the response mux live in `soc_bus_ctrl`.

## Test plan
- m0 reads 0x1000_0004, timer acks in cycle 1 with 0x0000_00AA → s_sel=5'b00010 in cycle 1; m0_ack=1, m0_rdata=0xAA, m0_err=0 in cycle 2; m1_ack stays 0.
- m0 and m1 request together three times in a row after reset → grants go m0, m1, m0. A lone m1 request is granted immediately regardless of the pointer.
- m1 writes 0x9000_0000 (unmapped) → s_req never rises; m1_ack=1, m1_err=1, m1_rdata=0 in cycle 1.
- m0 reads 0x2000_0000 and UART never acks (TIMEOUT=255) → s_req high for cycles 1..255; m0_ack=1, m0_err=1 in cycle 256.
- Slave acks in the same cycle the counter reaches TIMEOUT → data returned with err=0. An ack from an unselected slave in BUSY is ignored.
- rst driven low while in BUSY → s_req goes to 0 without waiting for a clock edge. After release the FSM is in IDLE, no stale ack is issued, and the next tie grants m0.

Source files
------------

// File: rtl/soc_bus_ctrl_pkg.sv
// soc_bus_ctrl_pkg: shared bus widths, slave indices and controller state encoding.
`default_nettype none

package soc_bus_ctrl_pkg;

  localparam int BUS_ADDR_WIDTH = 32;
  localparam int BUS_DATA_WIDTH = 32;

  localparam int SLV_RAM   = 0;
  localparam int SLV_TIMER = 1;
  localparam int SLV_UART  = 2;
  localparam int SLV_GPIO  = 3;
  localparam int SLV_SPI   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } bus_state_e;

endpackage

`default_nettype wire

// File: rtl/soc_bus_ctrl_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; the pointer records the last granted master.
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_grant_en,
  output logic [1:0] o_gnt
);

  logic r_last;

  // Reset to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_last <= 1'b1;
    else if (i_grant_en && (|i_req))
      r_last <= o_gnt[1];
  end

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/soc_bus_ctrl.sv
// soc_bus_ctrl: arbitrates two bus masters, decodes onto NUM_SLV slaves and
// runs one outstanding transaction with slave-timeout error reporting.
`default_nettype none

module soc_bus_ctrl
  import soc_bus_ctrl_pkg::*;
#(
  parameter int NUM_SLV = SLV_SPI + 1,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [31:0]             m0_addr,
  input  logic [31:0]             m0_wdata,
  output logic                    m0_ack,
  output logic [31:0]             m0_rdata,
  output logic                    m0_err,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [31:0]             m1_addr,
  input  logic [31:0]             m1_wdata,
  output logic                    m1_ack,
  output logic [31:0]             m1_rdata,
  output logic                    m1_err,
  output logic                    s_req,
  output logic [NUM_SLV-1:0]      s_sel,
  output logic                    s_we,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_wdata,
  input  logic [32*NUM_SLV-1:0]   s_rdata,
  input  logic [NUM_SLV-1:0]      s_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  bus_state_e         r_state, w_state_nxt;
  logic [1:0]         w_gnt;
  logic               w_grant, w_gnt_idx, r_gnt_idx;
  logic               w_we, r_we;
  logic [31:0]        w_addr, w_wdata, r_addr, r_wdata, r_rdata, w_slv_rdata;
  logic [NUM_SLV-1:0] w_sel, r_sel;
  logic               w_mapped, w_slv_ack, w_timeout, r_err, w_resp;
  logic [CW-1:0]      r_cnt, w_cnt_inc;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      ({m1_req, m0_req}),
    .i_grant_en (r_state == ST_IDLE),
    .o_gnt      (w_gnt)
  );

  assign w_grant   = |w_gnt;
  assign w_gnt_idx = w_gnt[1];
  assign w_we      = w_gnt_idx ? m1_we    : m0_we;
  assign w_addr    = w_gnt_idx ? m1_addr  : m0_addr;
  assign w_wdata   = w_gnt_idx ? m1_wdata : m0_wdata;
  assign w_mapped  = ({28'd0, w_addr[31:28]} < 32'(NUM_SLV));
  assign w_slv_ack = |(s_ack & r_sel);
  assign w_cnt_inc = r_cnt + CW'(1);
  // Next count reaching TIMEOUT marks the last BUSY cycle without an ack.
  assign w_timeout = (w_cnt_inc == CW'(TIMEOUT));

  always_comb begin
    w_sel       = '0;
    w_slv_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      w_sel[i]    = (w_addr[31:28] == 4'(i));
      w_slv_rdata = w_slv_rdata | (s_rdata[i*32 +: 32] & {32{r_sel[i]}});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant) w_state_nxt = w_mapped ? ST_BUSY : ST_RESP;
      ST_BUSY: if (w_slv_ack || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt_idx <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_grant) begin
          r_gnt_idx <= w_gnt_idx;
          r_we      <= w_we;
          r_addr    <= w_addr;
          r_wdata   <= w_wdata;
          r_sel     <= w_mapped ? w_sel : '0;
          r_cnt     <= '0;
          r_err     <= ~w_mapped;
          r_rdata   <= '0;
        end
        ST_BUSY: begin
          r_cnt <= w_cnt_inc;
          if (w_slv_ack) begin
            r_rdata <= w_slv_rdata;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s_req    = (r_state == ST_BUSY);
    s_sel    = s_req ? r_sel : '0;
    s_we     = r_we;
    s_addr   = r_addr;
    s_wdata  = r_wdata;
    w_resp   = (r_state == ST_RESP);
    m0_ack   = w_resp & ~r_gnt_idx;
    m1_ack   = w_resp &  r_gnt_idx;
    m0_rdata = m0_ack ? r_rdata : '0;
    m1_rdata = m1_ack ? r_rdata : '0;
    m0_err   = m0_ack & r_err;
    m1_err   = m1_ack & r_err;
  end

endmodule

`default_nettype wire

// File: tb/tb_soc_bus_ctrl.sv
// tb_soc_bus_ctrl: directed vector table plus arbitration and reset sequences.
`default_nettype none

module tb_soc_bus_ctrl;
  import soc_bus_ctrl_pkg::*;

  localparam int NS = 5;

  logic            clk, rst;
  logic            m0_req, m0_we, m1_req, m1_we;
  logic [31:0]     m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic            m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0]     m0_rdata, m1_rdata;
  logic            s_req, s_we;
  logic [NS-1:0]   s_sel, s_ack;
  logic [31:0]     s_addr, s_wdata;
  logic [32*NS-1:0] s_rdata;

  int n_cmp = 0;
  int n_fail = 0;

  soc_bus_ctrl #(.NUM_SLV(NS), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_req(s_req), .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_slv;
    int          ack_k;      // cycle the slave acks, 0 = never
    logic [31:0] sdata;
    int          spur_slv;
    int          spur_k;     // cycle of an ack from an unselected slave, 0 = none
    int          exp_cyc;    // cycle the master ack is expected
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [4:0]  exp_sel;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bg_rdata();
    for (int i = 0; i < NS; i++) s_rdata[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int n_sreq, n_selok, n_early;
    n_sreq = 0; n_selok = 0; n_early = 0;
    if (v.m == 0) begin
      m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
    end else begin
      m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
    end
    for (int cyc = 1; cyc <= v.exp_cyc; cyc++) begin
      @(posedge clk); #1;
      bg_rdata();
      s_ack = '0;
      if (cyc == v.spur_k) begin
        s_ack[v.spur_slv] = 1'b1;
        s_rdata[v.spur_slv*32 +: 32] = 32'hBAD0_BAD0;
      end
      if (cyc == v.ack_k) begin
        s_ack[v.ack_slv] = 1'b1;
        s_rdata[v.ack_slv*32 +: 32] = v.sdata;
      end
      @(negedge clk);
      if (cyc < v.exp_cyc) begin
        if (s_req) n_sreq++;
        if (s_req && s_sel == v.exp_sel) n_selok++;
        if (m0_ack || m1_ack) n_early++;
        if (cyc == 1 && v.exp_sel != 5'd0) begin
          check({name, " s_addr"}, 64'(s_addr), 64'(v.addr));
          check({name, " s_we/wdata"}, 64'({s_we, s_wdata}), 64'({v.we, v.wdata}));
        end
      end else begin
        check({name, " s_req count"}, 64'(n_sreq), (v.exp_sel != 5'd0) ? 64'(v.exp_cyc - 1) : 64'd0);
        check({name, " s_sel count"}, 64'(n_selok), 64'(n_sreq));
        check({name, " early ack"}, 64'(n_early), 64'd0);
        check({name, " acks"}, 64'({m1_ack, m0_ack}), (v.m == 1) ? 64'd2 : 64'd1);
        check({name, " rdata"}, 64'((v.m == 1) ? m1_rdata : m0_rdata), 64'(v.exp_rdata));
        check({name, " err"}, 64'((v.m == 1) ? m1_err : m0_err), 64'(v.exp_err));
        check({name, " other rdata/err"}, 64'((v.m == 1) ? {m0_err, m0_rdata} : {m1_err, m1_rdata}), 64'd0);
        check({name, " s_req in resp"}, 64'(s_req), 64'd0);
      end
    end
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0; s_ack = '0;
    @(negedge clk);
    check({name, " idle after"}, 64'({s_req, m1_ack, m0_ack}), 64'd0);
    @(posedge clk); #1;
  endtask

  // Both masters use fixed addresses so the winner is visible on s_addr.
  task automatic arb_round(input logic r0, input logic r1, input int win, input string name);
    m0_req = r0; m0_we = 1'b0; m0_addr = 32'h0000_0040;
    m1_req = r1; m1_we = 1'b0; m1_addr = 32'h1000_0080;
    @(posedge clk); #1;
    s_ack = s_sel;
    @(negedge clk);
    check({name, " s_addr"}, 64'(s_addr), (win == 1) ? 64'h1000_0080 : 64'h0000_0040);
    @(posedge clk); #1;
    s_ack = '0;
    @(negedge clk);
    check({name, " ack"}, 64'({m1_ack, m0_ack}), (win == 1) ? 64'd2 : 64'd1);
    @(posedge clk); #1;
    if (win == 1) m1_req = 1'b0; else m0_req = 1'b0;
  endtask

  initial begin
    int n_bad;
    rst = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    s_ack = '0; bg_rdata();

    //        m  we    addr          wdata         aslv       ak   sdata         sslv     sk ecyc err rdata         sel
    vecs[0] = '{0, 1'b0, 32'h1000_0004, 32'h0,       SLV_TIMER, 1,   32'h0000_00AA, 0,       0, 2,   0, 32'h0000_00AA, 5'b00010};
    vecs[1] = '{1, 1'b1, 32'h9000_0000, 32'h1111,    0,         0,   32'h0,         0,       0, 1,   1, 32'h0,         5'b00000};
    vecs[2] = '{1, 1'b0, 32'h0000_0010, 32'h0,       SLV_RAM,   3,   32'hDEAD_BEEF, 0,       0, 4,   0, 32'hDEAD_BEEF, 5'b00001};
    vecs[3] = '{0, 1'b1, 32'h3000_0008, 32'hC0FF_EE00, SLV_GPIO, 2,  32'h1234_5678, 0,       0, 3,   0, 32'h1234_5678, 5'b01000};
    vecs[4] = '{1, 1'b0, 32'h4000_0000, 32'h0,       SLV_SPI,   1,   32'hCAFE_F00D, 0,       0, 2,   0, 32'hCAFE_F00D, 5'b10000};
    vecs[5] = '{0, 1'b0, 32'h5000_0000, 32'h0,       0,         0,   32'h0,         0,       0, 1,   1, 32'h0,         5'b00000};
    vecs[6] = '{0, 1'b0, 32'h2000_0000, 32'h0,       SLV_UART,  0,   32'h0,         0,       0, 256, 1, 32'h0,         5'b00100};
    vecs[7] = '{0, 1'b0, 32'h2000_0000, 32'h0,       SLV_UART,  255, 32'h0000_0055, 0,       0, 256, 0, 32'h0000_0055, 5'b00100};
    vecs[8] = '{1, 1'b0, 32'h1000_0000, 32'h0,       SLV_TIMER, 3,   32'h0000_0077, SLV_RAM, 1, 4,   0, 32'h0000_0077, 5'b00010};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset s_req/sel/we", 64'({s_req, s_sel, s_we}), 64'd0);
    check("reset s_addr/wdata", {s_addr, s_wdata}, 64'd0);
    check("reset m0 outputs", 64'({m0_ack, m0_err, m0_rdata}), 64'd0);
    check("reset m1 outputs", 64'({m1_ack, m1_err, m1_rdata}), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    arb_round(1'b1, 1'b1, 0, "tie1");
    arb_round(1'b1, 1'b1, 1, "tie2");
    arb_round(1'b1, 1'b1, 0, "tie3");
    arb_round(1'b1, 1'b0, 0, "lone m0");
    arb_round(1'b0, 1'b1, 1, "lone m1");
    arb_round(1'b1, 1'b1, 0, "tie4");
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset during BUSY; m1 owns the transaction so a surviving pointer would favour m0 anyway,
    // hence the follow-up tie uses m1 as last grant before the reset.
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h2000_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre-reset s_req", 64'(s_req), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("async reset s_req/sel", 64'({s_req, s_sel}), 64'd0);
    m1_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (m0_ack || m1_ack || s_req) n_bad++;
    end
    check("post-reset stale ack", 64'(n_bad), 64'd0);
    @(posedge clk); #1;
    arb_round(1'b1, 1'b1, 0, "tie after reset");
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
